// File: rtl/bsg_upstream_ch_tx.sv
// Channel link transmitter: buffers 16-bit core words and sends them as two
// 8-bit io beats (low byte first) under token/credit flow control.
module bsg_upstream_ch_tx #(
  parameter int WORD_W      = 16,
  parameter int CHAN_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int CREDITS     = 16,
  parameter int TOKEN_DECIM = 4,
  localparam int CW         = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] core_data_i,
  input  logic              core_valid_i,
  output logic              core_ready_o,
  output logic [CHAN_W-1:0] io_data_o,
  output logic              io_valid_o,
  input  logic              io_token_i,
  output logic [CW-1:0]     credits_o,
  output logic              busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND_LO,
    SEND_HI
  } state_e;

  state_e state_q, state_d;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wptr_q, rptr_q, count;
  logic              full, empty, enq, launch;
  logic [WORD_W-1:0] head;

  logic [CHAN_W-1:0] hi_q, hi_d;
  logic [CHAN_W-1:0] io_data_q, io_data_d;
  logic              io_valid_q, io_valid_d;

  logic              tok_s1_q, tok_s2_q, tok_prev_q, tok_rise;
  logic [CW-1:0]     credits_q, credits_d;
  logic [CW:0]       cred_sum;

  assign count = wptr_q - rptr_q;
  assign full  = count == (AW+1)'(FIFO_DEPTH);
  assign empty = wptr_q == rptr_q;
  assign enq   = core_valid_i & ~full;
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (enq) mem_q[wptr_q[AW-1:0]] <= core_data_i;
  end

  assign tok_rise = tok_s2_q & ~tok_prev_q;

  // Launch uses the pre-token credit count; the sum is one bit wider so
  // the clamp can see an overflow attempt.
  always_comb begin
    cred_sum = {1'b0, credits_q} - (CW+1)'(launch);
    if (tok_rise) cred_sum = cred_sum + (CW+1)'(TOKEN_DECIM);
    if (cred_sum > (CW+1)'(CREDITS)) credits_d = CW'(CREDITS);
    else                             credits_d = cred_sum[CW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    io_data_d  = io_data_q;
    io_valid_d = 1'b0;
    launch     = 1'b0;
    unique case (state_q)
      IDLE, SEND_HI: begin
        if (!empty && credits_q != '0) begin
          launch     = 1'b1;
          hi_d       = head[WORD_W-1:CHAN_W];
          io_data_d  = head[CHAN_W-1:0];
          io_valid_d = 1'b1;
          state_d    = SEND_LO;
        end else begin
          state_d    = IDLE;
        end
      end
      SEND_LO: begin
        io_data_d  = hi_q;
        io_valid_d = 1'b1;
        state_d    = SEND_HI;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      hi_q       <= '0;
      io_data_q  <= '0;
      io_valid_q <= 1'b0;
      tok_s1_q   <= 1'b0;
      tok_s2_q   <= 1'b0;
      tok_prev_q <= 1'b0;
      credits_q  <= CW'(CREDITS);
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      io_data_q  <= io_data_d;
      io_valid_q <= io_valid_d;
      tok_s1_q   <= io_token_i;
      tok_s2_q   <= tok_s1_q;
      tok_prev_q <= tok_s2_q;
      credits_q  <= credits_d;
      if (enq)    wptr_q <= wptr_q + 1'b1;
      if (launch) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign core_ready_o = ~full;
  assign io_data_o    = io_data_q;
  assign io_valid_o   = io_valid_q;
  assign credits_o    = credits_q;
  assign busy_o       = ~empty | (state_q != IDLE);

endmodule

// File: tb/tb_bsg_upstream_ch_tx.sv
// Self-checking bench for bsg_upstream_ch_tx: directed scenarios plus a
// randomized run against a word/beat/credit scoreboard.
module tb_bsg_upstream_ch_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] core_data_i;
  logic        core_valid_i;
  logic        core_ready_o;
  logic [7:0]  io_data_o;
  logic        io_valid_o;
  logic        io_token_i;
  logic [4:0]  credits_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] obs[$];
  int         obs_cyc[$];
  logic [7:0] exp_q[$];

  bsg_upstream_ch_tx dut (
    .clk         (clk),
    .rst         (rst),
    .core_data_i (core_data_i),
    .core_valid_i(core_valid_i),
    .core_ready_o(core_ready_o),
    .io_data_o   (io_data_o),
    .io_valid_o  (io_valid_o),
    .io_token_i  (io_token_i),
    .credits_o   (credits_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (io_valid_o) begin
      obs.push_back(io_data_o);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    core_valid_i = 1'b0;
    io_token_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    obs.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  // Offers a word until accepted; returns 1ns after the accepting edge.
  task automatic push_word(input logic [15:0] w, output int waits);
    bit ok;
    ok = 0;
    waits = 0;
    @(negedge clk);
    core_valid_i = 1'b1;
    core_data_i  = w;
    for (int i = 0; i < 200; i++) begin
      if (core_ready_o) begin
        ok = 1;
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        @(posedge clk);
        #1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    core_valid_i = 1'b0;
    if (!ok) begin
      failures++;
      $display("FAIL push_timeout: word %h not accepted in 200 cycles", w);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (core_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", core_ready_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", busy_o);
    end
    checks++;
    if (io_valid_o !== 1'b0 || io_data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_io: got v=%b d=%h want v=0 d=00",
               io_valid_o, io_data_o);
    end
    checks++;
    if (credits_o !== 5'd16) begin
      failures++;
      $display("FAIL reset_credits: got %0d want 16", credits_o);
    end
  endtask

  task automatic test_single();
    int w;
    do_reset();
    push_word(16'hBEEF, w);
    checks++;
    if (io_valid_o !== 1'b0 || credits_o !== 5'd16) begin
      failures++;
      $display("FAIL single_t0: got v=%b cr=%0d want v=0 cr=16",
               io_valid_o, credits_o);
    end
    wait_cycles(1);
    checks++;
    if (io_valid_o !== 1'b1 || io_data_o !== 8'hEF || credits_o !== 5'd15) begin
      failures++;
      $display("FAIL single_lo: got v=%b d=%h cr=%0d want v=1 d=ef cr=15",
               io_valid_o, io_data_o, credits_o);
    end
    wait_cycles(1);
    checks++;
    if (io_valid_o !== 1'b1 || io_data_o !== 8'hBE || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL single_hi: got v=%b d=%h busy=%b want v=1 d=be busy=1",
               io_valid_o, io_data_o, busy_o);
    end
    wait_cycles(1);
    checks++;
    if (io_valid_o !== 1'b0 || busy_o !== 1'b0 || io_data_o !== 8'hBE) begin
      failures++;
      $display("FAIL single_done: got v=%b busy=%b d=%h want v=0 busy=0 d=be",
               io_valid_o, busy_o, io_data_o);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int tot;
    do_reset();
    tot = 0;
    for (int i = 1; i <= 4; i++) begin
      push_word(16'(i), w);
      tot += w;
    end
    checks++;
    if (tot != 0) begin
      failures++;
      $display("FAIL b2b_ready: ready low for %0d cycles want 0", tot);
    end
    wait_cycles(12);
    checks++;
    if (obs.size() != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d beats want 8", obs.size());
    end else begin
      checks++;
      if (obs_cyc[7] - obs_cyc[0] != 7) begin
        failures++;
        $display("FAIL b2b_contig: beats span %0d cycles want 7",
                 obs_cyc[7] - obs_cyc[0]);
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (obs[k] !== exp_q[k]) begin
          failures++;
          $display("FAIL b2b_beat%0d: got %h want %h", k, obs[k], exp_q[k]);
        end
      end
    end
    checks++;
    if (credits_o !== 5'd12) begin
      failures++;
      $display("FAIL b2b_credits: got %0d want 12", credits_o);
    end
  endtask

  task automatic test_credit_exhaust();
    int w;
    do_reset();
    for (int i = 0; i < 20; i++) push_word(16'($urandom), w);
    wait_cycles(40);
    checks++;
    if (obs.size() != 32) begin
      failures++;
      $display("FAIL exhaust_count: got %0d beats want 32", obs.size());
    end
    for (int k = 0; k < 32 && k < obs.size(); k++) begin
      checks++;
      if (obs[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL exhaust_beat%0d: got %h want %h", k, obs[k], exp_q[k]);
      end
    end
    checks++;
    if (io_valid_o !== 1'b0 || credits_o !== 5'd0 ||
        core_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL exhaust_state: got v=%b cr=%0d rdy=%b busy=%b want 0 0 0 1",
               io_valid_o, credits_o, core_ready_o, busy_o);
    end
  endtask

  task automatic test_token_refill();
    @(negedge clk);
    io_token_i = 1'b1;
    wait_cycles(3);
    checks++;
    if (credits_o !== 5'd4) begin
      failures++;
      $display("FAIL refill_credits: got %0d want 4", credits_o);
    end
    wait_cycles(2);
    @(negedge clk);
    io_token_i = 1'b0;
    wait_cycles(30);
    checks++;
    if (obs.size() != 40) begin
      failures++;
      $display("FAIL refill_count: got %0d beats want 40", obs.size());
    end
    for (int k = 32; k < 40 && k < obs.size(); k++) begin
      checks++;
      if (obs[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL refill_beat%0d: got %h want %h", k, obs[k], exp_q[k]);
      end
    end
    checks++;
    if (credits_o !== 5'd0 || core_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL refill_state: got cr=%0d rdy=%b busy=%b want 0 1 0",
               credits_o, core_ready_o, busy_o);
    end
  endtask

  task automatic test_token_launch();
    int w;
    do_reset();
    for (int i = 0; i < 11; i++) push_word(16'($urandom), w);
    wait_cycles(30);
    checks++;
    if (credits_o !== 5'd5 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL tl_setup: got cr=%0d busy=%b want 5 0", credits_o, busy_o);
    end
    @(negedge clk);
    io_token_i = 1'b1;
    @(posedge clk);
    push_word(16'h5A5A, w);
    checks++;
    if (credits_o !== 5'd5) begin
      failures++;
      $display("FAIL tl_before: got %0d want 5", credits_o);
    end
    wait_cycles(1);
    checks++;
    if (credits_o !== 5'd8 || io_valid_o !== 1'b1 || io_data_o !== 8'h5A) begin
      failures++;
      $display("FAIL tl_same_cycle: got cr=%0d v=%b d=%h want 8 1 5a",
               credits_o, io_valid_o, io_data_o);
    end
    @(negedge clk);
    io_token_i = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    push_word(16'h1234, w);
    wait_cycles(1);
    checks++;
    if (io_valid_o !== 1'b1 || io_data_o !== 8'h34) begin
      failures++;
      $display("FAIL mid_lo: got v=%b d=%h want 1 34", io_valid_o, io_data_o);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(1);
    checks++;
    if (io_valid_o !== 1'b0 || io_data_o !== 8'h00 || credits_o !== 5'd16 ||
        core_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got v=%b d=%h cr=%0d rdy=%b busy=%b want 0 00 16 1 0",
               io_valid_o, io_data_o, credits_o, core_ready_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    obs.delete();
    obs_cyc.delete();
    wait_cycles(6);
    checks++;
    if (obs.size() != 0) begin
      failures++;
      $display("FAIL mid_no_hi: got %0d beats after reset want 0", obs.size());
    end
  endtask

  task automatic test_random();
    int  rises, nwords, hold, expc;
    bit  done;
    do_reset();
    rises  = 0;
    nwords = 0;
    hold   = 10;
    done   = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i >= 150 && !busy_o && !io_token_i && hold >= 4) begin
        done = 1;
        break;
      end
      core_valid_i = (i < 150) && ($urandom_range(0, 1) == 1);
      core_data_i  = 16'($urandom);
      if (core_valid_i && core_ready_o) begin
        exp_q.push_back(core_data_i[7:0]);
        exp_q.push_back(core_data_i[15:8]);
        nwords++;
      end
      hold++;
      if (io_token_i && hold >= 3) begin
        io_token_i = 1'b0;
        hold = 0;
      end else if (!io_token_i && hold >= 3 && credits_o <= 5'd12 &&
                   $urandom_range(0, 2) == 0) begin
        io_token_i = 1'b1;
        hold = 0;
        rises++;
      end
    end
    core_valid_i = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL rand_drain: link not idle after 3000 cycles");
    end
    expc = 16 + 4 * rises - nwords;
    checks++;
    if (int'(credits_o) != expc) begin
      failures++;
      $display("FAIL rand_credits: got %0d want %0d", credits_o, expc);
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count: got %0d beats want %0d", obs.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs.size(); k++) begin
      checks++;
      if (obs[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL rand_beat%0d: got %h want %h", k, obs[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    core_valid_i = 1'b0;
    core_data_i  = '0;
    io_token_i   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_credit_exhaust();
    test_token_refill();
    test_token_launch();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
